// File: rtl/gray_display_pkg.sv
// Shared types and constants for the Gray display sequencer.
// The mode enum, digit count and mode-to-LED mapping live here.
package gray_display_pkg;

  typedef enum logic [1:0] {
    MODE_MANUAL = 2'd0,
    MODE_AUTO   = 2'd1,
    MODE_STEP   = 2'd2
  } mode_t;

  localparam int N_DIGITS = 2;

  localparam logic [N_DIGITS-1:0] AN_BLANK = 2'b11;
  localparam logic [N_DIGITS-1:0] AN_CUR   = 2'b10;
  localparam logic [N_DIGITS-1:0] AN_PREV  = 2'b01;

  function automatic logic [2:0] mode_to_led(input mode_t m);
    unique case (m)
      MODE_AUTO: return 3'b010;
      MODE_STEP: return 3'b100;
      default:   return 3'b001;
    endcase
  endfunction

endpackage

// File: rtl/gray_display_if.sv
// Board-side bundle: switches and buttons in,
// decoder code, anodes and mode LEDs out.
interface gray_display_if;
  import gray_display_pkg::*;

  logic [3:0]          sw;
  logic                btn_mode;
  logic                btn_step;
  logic [3:0]          code;
  logic [N_DIGITS-1:0] an_n;
  logic [2:0]          mode_led;

  modport master (
    output sw, btn_mode, btn_step,
    input  code, an_n, mode_led
  );

  modport slave (
    input  sw, btn_mode, btn_step,
    output code, an_n, mode_led
  );

endinterface

// File: rtl/gray_display_sequencer_btn.sv
// Button conditioner: 2-FF sync, rising-edge pulse and
// a lockout window that swallows bounce after each press.
module btn_conditioner #(
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_pulse
);

  localparam int CW =
    (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

  logic          r_s1;
  logic          r_s2;
  logic          r_s3;
  logic [CW-1:0] r_lock;
  logic          w_edge;

  assign w_edge  = r_s2 & ~r_s3;
  assign o_pulse = w_edge && (r_lock == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_s3   <= 1'b0;
      r_lock <= '0;
    end else begin
      r_s1 <= i_btn;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
      // next accept lands DEBOUNCE_CYC cycles after this one
      if (o_pulse)
        r_lock <= CW'(DEBOUNCE_CYC - 1);
      else if (r_lock != '0)
        r_lock <= r_lock - CW'(1);
    end
  end

endmodule

// File: rtl/gray_display_sequencer.sv
// Selects the value for the shared Gray decoder and
// scans it across the current/previous digit pair.
module gray_display_sequencer
  import gray_display_pkg::*;
#(
  parameter int TICK_DIV     = 50_000_000,
  parameter int SCAN_DIV     = 50_000,
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input logic           clk,
  input logic           rst_n,
  gray_display_if.slave bus
);

  localparam int TW  =
    (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SCW =
    (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [3:0]          r_sw1;
  logic [3:0]          r_sw2;
  logic                w_mode_p;
  logic                w_step_p;
  mode_t               r_mode;
  mode_t               w_mode_nxt;
  logic [3:0]          r_cur;
  logic [3:0]          w_cur_nxt;
  logic [3:0]          r_prev;
  logic [3:0]          w_prev_nxt;
  logic [TW-1:0]       r_tick;
  logic [TW-1:0]       w_tick_nxt;
  logic                w_tick;
  logic [SCW-1:0]      r_scan;
  logic [SCW-1:0]      w_scan_nxt;
  logic                w_wrap;
  logic                r_sel;
  logic                w_sel_nxt;
  logic [3:0]          r_code;
  logic [N_DIGITS-1:0] r_an;
  logic [2:0]          r_led;

  btn_conditioner #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_btn_mode (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_btn   (bus.btn_mode),
    .o_pulse (w_mode_p)
  );

  btn_conditioner #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_btn_step (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_btn   (bus.btn_step),
    .o_pulse (w_step_p)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_mode <= MODE_MANUAL;
    else        r_mode <= w_mode_nxt;
  end

  always_comb begin
    w_mode_nxt = r_mode;
    if (w_mode_p) begin
      unique case (r_mode)
        MODE_MANUAL: w_mode_nxt = MODE_AUTO;
        MODE_AUTO:   w_mode_nxt = MODE_STEP;
        default:     w_mode_nxt = MODE_MANUAL;
      endcase
    end
  end

  // a mode pulse freezes cur and beats any coincident tick/step
  always_comb begin
    w_tick = (r_mode == MODE_AUTO) &&
             (r_tick == TW'(TICK_DIV - 1));
    w_tick_nxt = '0;
    if (r_mode == MODE_AUTO && !w_mode_p && !w_tick)
      w_tick_nxt = r_tick + TW'(1);
    w_cur_nxt = r_cur;
    if (!w_mode_p) begin
      unique case (r_mode)
        MODE_MANUAL: w_cur_nxt = r_sw2;
        MODE_AUTO:
          if (w_tick) w_cur_nxt = r_cur + 4'd1;
        MODE_STEP:
          if (w_step_p) w_cur_nxt = r_cur + 4'd1;
        default: w_cur_nxt = r_cur;
      endcase
    end
    w_prev_nxt = (w_cur_nxt != r_cur) ? r_cur : r_prev;
    w_wrap     = (r_scan == SCW'(SCAN_DIV - 1));
    w_scan_nxt = w_wrap ? '0 : r_scan + SCW'(1);
    w_sel_nxt  = r_sel ^ w_wrap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sw1  <= '0;
      r_sw2  <= '0;
      r_cur  <= '0;
      r_prev <= '0;
      r_tick <= '0;
      r_scan <= '0;
      r_sel  <= 1'b0;
      r_code <= '0;
      r_an   <= AN_CUR;
      r_led  <= mode_to_led(MODE_MANUAL);
    end else begin
      r_sw1  <= bus.sw;
      r_sw2  <= r_sw1;
      r_cur  <= w_cur_nxt;
      r_prev <= w_prev_nxt;
      r_tick <= w_tick_nxt;
      r_scan <= w_scan_nxt;
      r_sel  <= w_sel_nxt;
      r_code <= w_sel_nxt ? w_prev_nxt : w_cur_nxt;
      r_an   <= w_wrap ? AN_BLANK :
                (w_sel_nxt ? AN_PREV : AN_CUR);
      r_led  <= mode_to_led(w_mode_nxt);
    end
  end

  assign bus.code     = r_code;
  assign bus.an_n     = r_an;
  assign bus.mode_led = r_led;

endmodule

// File: tb/tb_gray_display_sequencer.sv
// Bench for gray_display_sequencer: switch vector table,
// scoreboard of expected cur/prev/led, timing corner sequences.
module tb_gray_display_sequencer;

  localparam int TICK = 4;
  localparam int SCAN = 3;
  localparam int DEB  = 5;

  typedef struct {
    logic [3:0] sw;
    logic [3:0] cur;
    logic [3:0] prev;
  } vec_t;

  typedef struct {
    logic [3:0] cur;
    logic [3:0] prev;
    logic [2:0] led;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  gray_display_if bus();

  gray_display_sequencer #(
    .TICK_DIV     (TICK),
    .SCAN_DIV     (SCAN),
    .DEBOUNCE_CYC (DEB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] p_cur;
  logic [3:0] p_prev;
  assign p_cur  = dut.r_cur;
  assign p_prev = dut.r_prev;

  // free-running scan reference: blank on first cycle of each digit
  int   m_cnt;
  logic m_sel;
  logic m_blank;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt   <= 0;
      m_sel   <= 1'b0;
      m_blank <= 1'b0;
    end else if (m_cnt == SCAN - 1) begin
      m_cnt   <= 0;
      m_sel   <= ~m_sel;
      m_blank <= 1'b1;
    end else begin
      m_cnt   <= m_cnt + 1;
      m_blank <= 1'b0;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string nm, input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic sb_check(input string nm);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got empty scoreboard want entry",
               nm);
    end else begin
      e = sb.pop_front();
      chk({nm, ".cur"}, int'(p_cur), int'(e.cur));
      chk({nm, ".prev"}, int'(p_prev), int'(e.prev));
      chk({nm, ".led"}, int'(bus.mode_led), int'(e.led));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    vec_t       vt[4];
    logic [3:0] m_cur;
    bit   [4:0] pat;
    int         ecode;
    int         ean;

    vt[0] = '{4'hA, 4'hA, 4'h0};
    vt[1] = '{4'h3, 4'h3, 4'hA};
    vt[2] = '{4'h3, 4'h3, 4'hA};
    vt[3] = '{4'hE, 4'hE, 4'h3};
    pat   = 5'b10101;

    rst_n        = 1'b0;
    bus.sw       = 4'h0;
    bus.btn_mode = 1'b0;
    bus.btn_step = 1'b0;
    #12;
    chk("rst.code", int'(bus.code), 'h0);
    chk("rst.an", int'(bus.an_n), 'h2);
    chk("rst.led", int'(bus.mode_led), 'h1);
    cyc(1);
    rst_n = 1'b1;
    cyc(2);

    // MANUAL: switch value lands 3 cycles after it changes
    for (int i = 0; i < 4; i++) begin
      bus.sw = vt[i].sw;
      sb.push_back('{vt[i].cur, vt[i].prev, 3'b001});
      cyc(2);
      chk("man.lat", int'(p_cur),
          (i == 0) ? 0 : int'(vt[i-1].cur));
      cyc(1);
      sb_check("man");
      cyc(2);
    end

    // scan: cur=E on digit 0, prev=3 on digit 1
    for (int i = 0; i < 2 * SCAN; i++) begin
      cyc(1);
      ean   = m_blank ? 'h3 : (m_sel ? 'h1 : 'h2);
      ecode = m_sel ? 'h3 : 'hE;
      chk("scan.an", int'(bus.an_n), ean);
      chk("scan.code", int'(bus.code), ecode);
    end

    // AUTO from 14: 15 at +4, 0 at +8, 1 at +12
    bus.btn_mode = 1'b1;
    cyc(3);
    chk("auto.led", int'(bus.mode_led), 'h2);
    chk("auto.entry", int'(p_cur), 'hE);
    bus.btn_mode = 1'b0;
    cyc(3);
    chk("auto.hold3", int'(p_cur), 'hE);
    cyc(1);
    chk("auto.15", int'(p_cur), 'hF);
    chk("auto.15p", int'(p_prev), 'hE);
    cyc(3);
    chk("auto.hold7", int'(p_cur), 'hF);
    cyc(1);
    chk("auto.wrap", int'(p_cur), 'h0);
    chk("auto.wrapp", int'(p_prev), 'hF);
    cyc(4);
    chk("auto.1", int'(p_cur), 'h1);

    // mode pulse lands on the same cycle as the next tick
    cyc(1);
    bus.btn_mode = 1'b1;
    cyc(2);
    chk("coll.pre", int'(bus.mode_led), 'h2);
    cyc(1);
    chk("coll.led", int'(bus.mode_led), 'h4);
    chk("coll.cur", int'(p_cur), 'h1);
    bus.btn_mode = 1'b0;
    cyc(3);

    // STEP: 16 presses walk all the way round back to 1
    m_cur = 4'h1;
    for (int i = 0; i < 16; i++) begin
      sb.push_back('{m_cur + 4'd1, m_cur, 3'b100});
      m_cur = m_cur + 4'd1;
      bus.btn_step = 1'b1;
      cyc(3);
      sb_check("step");
      bus.btn_step = 1'b0;
      cyc(3);
    end

    // both buttons together in STEP: mode wins
    bus.btn_mode = 1'b1;
    bus.btn_step = 1'b1;
    cyc(3);
    chk("both.led", int'(bus.mode_led), 'h1);
    chk("both.cur", int'(p_cur), 'h1);
    cyc(1);
    chk("both.load", int'(p_cur), 'hE);
    chk("both.prev", int'(p_prev), 'h1);
    bus.btn_mode = 1'b0;
    bus.btn_step = 1'b0;
    cyc(6);

    // step is ignored in MANUAL
    bus.btn_step = 1'b1;
    cyc(3);
    chk("mstep.cur", int'(p_cur), 'hE);
    chk("mstep.led", int'(bus.mode_led), 'h1);
    cyc(1);
    chk("mstep.prev", int'(p_prev), 'h1);
    bus.btn_step = 1'b0;
    cyc(6);

    // bouncy mode press: one advance only
    for (int j = 4; j >= 0; j--) begin
      bus.btn_mode = pat[j];
      cyc(1);
    end
    chk("bounce.one", int'(bus.mode_led), 'h2);
    cyc(8);
    chk("bounce.hold", int'(bus.mode_led), 'h2);
    bus.btn_mode = 1'b0;

    // asynchronous reset in the middle of counting
    bus.sw = 4'h0;
    cyc(5);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.code", int'(bus.code), 'h0);
    chk("arst.an", int'(bus.an_n), 'h2);
    chk("arst.led", int'(bus.mode_led), 'h1);
    chk("arst.cur", int'(p_cur), 'h0);
    chk("arst.prev", int'(p_prev), 'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(6);
    chk("arst.after", int'(p_cur), 'h0);
    chk("arst.mode", int'(bus.mode_led), 'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gray_display_sequencer.md
# gray_display_sequencer

Sequencing controller for the shared binary→Gray→7-segment decoder on the lab board. Selects the 4-bit value fed to that decoder from one of three modes: manual switches, free-running auto-count, or button single-step. Time-multiplexes the single decoder across two digits, current value and previous value, so the one-bit Gray change between successive values is visible. Sits between board switches/buttons and the decoder input; anode lines go straight to the board.

## Interface
- `TICK_DIV`, default 50_000_000: clk cycles per auto-count step (1 Hz at 50 MHz).
- `SCAN_DIV`, default 50_000: clk cycles each digit is driven, blanking cycle included.
- `DEBOUNCE_CYC`, default 1_000_000: lockout cycles after an accepted button press.
- `clk`  in  1  single system clock; all state on its rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `sw`  in  4  switch value {SW3..SW0}, asynchronous to clk.
- `btn_mode`  in  1  mode button, active-high, asynchronous, bouncy.
- `btn_step`  in  1  step button, active-high, asynchronous, bouncy.
- `code`  out  4  binary value to shared decoder.
- `an_n`  out  2  digit anodes, active-low; bit0 = current, bit1 = previous.
- `mode_led`  out  3  one-hot mode: 001 MANUAL, 010 AUTO, 100 STEP.

## Operation
- Inputs: `sw` and both buttons pass through 2-FF synchronizers.
- Buttons: rising edge of synchronized level → one-cycle pulse. Accepted pulse starts a `DEBOUNCE_CYC` lockout; all edges during lockout are ignored.
- Mode FSM is MANUAL → AUTO → STEP → MANUAL, advanced on each `btn_mode` pulse.
- MANUAL: `cur` loads synchronized `sw` every cycle.
- AUTO: `cur` increments by 1 every `TICK_DIV` cycles. Tick counter clears on entering AUTO.
- STEP: `cur` increments by 1 per `btn_step` pulse. `btn_step` is ignored in other modes.
- `cur` carries over unchanged on mode change.
- Arithmetic is 4-bit, mod 16: 15 wraps to 0.
- `prev` loads the old `cur` on every cycle where `cur` changes value. A reload with an identical value leaves `prev` unchanged.
- Scan: `sel` toggles every `SCAN_DIV` cycles.
  - `code` = `sel` ? `prev` : `cur`.
  - `an_n` = 2'b11 (blank) on the first cycle of each new `sel`.
  - Otherwise `an_n` = `sel` ? 2'b01 : 2'b10.
- Simultaneous events:
  - `btn_mode` and `btn_step` pulses in the same cycle: mode change wins, step dropped.
  - Auto tick coincides with mode pulse: mode change wins, no increment.
- Reset mid-operation: all state returns to its reset values immediately, with no completion of a pending step.

## Timing
- Reset values:
  - Outputs: `code`=0, `an_n`=2'b10, `mode_led`=3'b001.
  - Internal state: `cur`=0, `prev`=0, `sel`=0, all counters 0, lockouts inactive.
- All outputs are registered.
- `sw` change → `cur` updated 3 cycles later: 2 sync + 1 load. Visible on `code` in the same cycle if `sel`=0.
- Button level rise → mode/`cur` update on cycle 3: 2 sync, edge detect, then register.
- A second press is accepted no earlier than `DEBOUNCE_CYC` cycles after the first accepted pulse.
- Auto increments are exactly `TICK_DIV` cycles apart. The first increment comes `TICK_DIV` cycles after AUTO entry.
- Digit period is `SCAN_DIV` cycles: 1 blank cycle plus `SCAN_DIV`−1 driven cycles.

## Structure
- Package `gray_display_pkg`:
  - `mode_t` enum: MODE_MANUAL, MODE_AUTO, MODE_STEP.
  - Constants `N_DIGITS`=2 and `AN_BLANK`=2'b11.
  - Constant mapping `mode_t` to `mode_led`.
- Sub-module `btn_conditioner` (synchronizer, edge detect, lockout counter, parameter `DEBOUNCE_CYC`), instantiated once per button.
- Top holds the mode FSM, `cur`/`prev` registers, tick divider and scan counter.

## Test plan
Bench parameters: `TICK_DIV`=4, `SCAN_DIV`=3, `DEBOUNCE_CYC`=5.
- Reset: deassert `rst_n` mid-count → `code`=0, `an_n`=2'b10, `mode_led`=001 immediately, asynchronously.
- MANUAL: `sw`=4'hA, then 4'h3 → `cur`=A at cycle+3, then `cur`=3 with `prev`=A. `code` alternates 3/A with `an_n` 10, 11, 01, 11 pattern per scan.
- Mode cycling and debounce:
  - 3 clean `btn_mode` presses ≥5 cycles apart → `mode_led` 010, 100, 001.
  - Bounce burst of 4 edges within 5 cycles → exactly one mode advance.
- AUTO wrap: from `cur`=14 enter AUTO → 15 after 4 cycles, 0 after 8 (`prev`=15), 1 after 12.
- STEP: 16 clean `btn_step` presses from 0 → `cur` returns to 0. `btn_step` pulsed in MANUAL → no change.
- Collisions:
  - `btn_mode` and `btn_step` rise in the same cycle while in STEP → mode goes to MANUAL, `cur` unchanged.
  - Mode pulse coinciding with an AUTO tick → no increment.
